// File: rtl/misa_o_pkg.sv
`default_nettype none
// ------------------------------------------------------------------------
// misa_o_pkg: opcodes, width modes and FSM states for misa_o.   Rev 1.0
// ------------------------------------------------------------------------
package misa_o_pkg;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_LDI  = 4'h1;
  localparam logic [3:0] OP_INC  = 4'h2;
  localparam logic [3:0] OP_DEC  = 4'h3;
  localparam logic [3:0] OP_NOT  = 4'h4;
  localparam logic [3:0] OP_XMEM = 4'h5;
  localparam logic [3:0] OP_XOP  = 4'hF;

  localparam logic [3:0] XOP_CFG = 4'h0;
  localparam logic [3:0] XOP_SA  = 4'h1;
  localparam logic [3:0] XOP_RSA = 4'h2;

  localparam logic [7:0] CFG_RESET = 8'h4C;

  typedef enum logic [1:0] {
    W_UL   = 2'b00,
    W_LK8  = 2'b01,
    W_LK16 = 2'b10
  } width_e;

  typedef enum logic [2:0] {
    S_FETCH = 3'd0,
    S_IMM   = 3'd1,
    S_XOPX  = 3'd2,
    S_CFG0  = 3'd3,
    S_CFG1  = 3'd4,
    S_XFUNC = 3'd5,
    S_MEM0  = 3'd6,
    S_MEM1  = 3'd7
  } state_e;

  // Mode 2'b11 is folded onto LK16.
  function automatic width_e cfg_width(input logic [1:0] mode);
    width_e w;
    case (mode)
      2'b00:   w = W_UL;
      2'b01:   w = W_LK8;
      default: w = W_LK16;
    endcase
    return w;
  endfunction

  function automatic logic [15:0] width_mask(input width_e w);
    logic [15:0] m;
    case (w)
      W_UL:    m = 16'h000F;
      W_LK8:   m = 16'h00FF;
      default: m = 16'hFFFF;
    endcase
    return m;
  endfunction

  function automatic logic [1:0] last_nibble(input width_e w);
    logic [1:0] n;
    case (w)
      W_UL:    n = 2'd0;
      W_LK8:   n = 2'd1;
      default: n = 2'd3;
    endcase
    return n;
  endfunction

endpackage
`default_nettype wire

// File: rtl/misa_o_agu.sv
`default_nettype none
// ------------------------------------------------------------------------
// misa_o_agu: XMEM effective address and pointer update.        Rev 1.0
// ------------------------------------------------------------------------
module misa_o_agu
  import misa_o_pkg::*;
(
  input  logic [15:0] ra_i,
  input  logic        am_i,
  input  logic        dir_i,
  input  width_e      width_i,
  output logic [15:0] ea_o,
  output logic [15:0] ea_p1_o,
  output logic [15:0] ra_upd_o
);

  logic [15:0] w_step;

  assign w_step = (width_i == W_LK16) ? 16'd2 : 16'd1;

  // Pre-decrement writes the effective address back; post-increment steps past it.
  always_comb begin
    if (dir_i) begin
      ea_o     = am_i ? (ra_i - w_step) : ra_i;
      ra_upd_o = ea_o;
    end else begin
      ea_o     = ra_i;
      ra_upd_o = am_i ? (ra_i + w_step) : ra_i;
    end
  end

  assign ea_p1_o = ea_o + 16'd1;

endmodule
`default_nettype wire

// File: rtl/misa_o.sv
`default_nettype none
// ------------------------------------------------------------------------
// misa_o: nibble-serial accumulator core, 16-bit datapath.      Rev 1.0
// ------------------------------------------------------------------------
module misa_o
  import misa_o_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  output logic        mem_enable_read,
  output logic        mem_enable_write,
  input  logic [7:0]  mem_data_in,
  output logic [14:0] mem_addr,
  output logic        mem_rw,
  output logic [7:0]  mem_data_out,
  output logic [15:0] test_data,
  output logic        test_carry
);

  state_e      state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic [15:0] acc_q, acc_d;
  logic [15:0] ra0_q, ra0_d;
  logic [15:0] ra1_q, ra1_d;
  logic        carry_q, carry_d;
  logic [7:0]  cfg_q, cfg_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [15:0] imm_q, imm_d;
  logic [3:0]  func_q, func_d;

  logic [3:0]  w_nib;
  width_e      w_width;
  logic [15:0] w_mask;
  logic [15:0] w_acc_w;
  logic [15:0] w_imm_next;
  logic [15:0] w_ra_sel;
  logic [15:0] w_ea;
  logic [15:0] w_ea_p1;
  logic [15:0] w_ra_upd;
  logic        w_rd;
  logic        w_wr;
  logic [14:0] w_addr;
  logic [7:0]  w_dout;
  logic        w_unused;

  assign w_nib      = pc_q[0] ? mem_data_in[7:4] : mem_data_in[3:0];
  assign w_width    = cfg_width(cfg_q[1:0]);
  assign w_mask     = width_mask(w_width);
  assign w_acc_w    = acc_q & w_mask;
  assign w_imm_next = imm_q | ({12'h000, w_nib} << {cnt_q, 2'b00});
  assign w_ra_sel   = func_q[0] ? ra1_q : ra0_q;
  assign w_unused   = ^{cfg_q[7:2], w_ea[15], w_ea_p1[15]};

  misa_o_agu u_agu (
    .ra_i     (w_ra_sel),
    .am_i     (func_q[2]),
    .dir_i    (func_q[1]),
    .width_i  (w_width),
    .ea_o     (w_ea),
    .ea_p1_o  (w_ea_p1),
    .ra_upd_o (w_ra_upd)
  );

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    acc_d   = acc_q;
    ra0_d   = ra0_q;
    ra1_d   = ra1_q;
    carry_d = carry_q;
    cfg_d   = cfg_q;
    cnt_d   = cnt_q;
    imm_d   = imm_q;
    func_d  = func_q;
    w_rd    = 1'b0;
    w_wr    = 1'b0;
    w_addr  = 15'h0000;
    w_dout  = 8'h00;

    // Every state except the data cycles consumes one instruction nibble.
    if (state_q != S_MEM0 && state_q != S_MEM1) begin
      w_rd   = 1'b1;
      w_addr = pc_q[15:1];
      pc_d   = pc_q + 16'd1;
    end

    case (state_q)
      S_FETCH: begin
        case (w_nib)
          OP_LDI: begin
            state_d = S_IMM;
            cnt_d   = 2'd0;
            imm_d   = 16'h0000;
          end
          OP_INC: begin
            acc_d   = (acc_q + 16'd1) & w_mask;
            carry_d = (w_acc_w == w_mask);
          end
          OP_DEC: begin
            acc_d   = (acc_q - 16'd1) & w_mask;
            carry_d = (w_acc_w == 16'h0000);
          end
          OP_NOT:  acc_d   = ~acc_q & w_mask;
          OP_XMEM: state_d = S_XFUNC;
          OP_XOP:  state_d = S_XOPX;
          default: ;
        endcase
      end
      S_IMM: begin
        imm_d = w_imm_next;
        if (cnt_q == last_nibble(w_width)) begin
          acc_d   = w_imm_next;
          state_d = S_FETCH;
        end else begin
          cnt_d = cnt_q + 2'd1;
        end
      end
      S_XOPX: begin
        state_d = S_FETCH;
        case (w_nib)
          XOP_CFG: state_d = S_CFG0;
          XOP_SA: begin
            ra1_d = ra0_q;
            ra0_d = acc_q;
          end
          XOP_RSA: begin
            ra0_d = ra1_q;
            ra1_d = ra0_q;
          end
          default: ;
        endcase
      end
      S_CFG0: begin
        imm_d[3:0] = w_nib;
        state_d    = S_CFG1;
      end
      S_CFG1: begin
        cfg_d   = {w_nib, imm_q[3:0]};
        state_d = S_FETCH;
      end
      S_XFUNC: begin
        func_d  = w_nib;
        state_d = S_MEM0;
      end
      S_MEM0: begin
        w_addr = w_ea[14:0];
        if (func_q[3]) begin
          w_wr   = 1'b1;
          w_dout = (w_width == W_UL) ? {4'h0, acc_q[3:0]} : acc_q[7:0];
        end else begin
          w_rd = 1'b1;
        end
        if (w_width == W_LK16) begin
          imm_d[7:0] = mem_data_in;
          state_d    = S_MEM1;
        end else begin
          if (!func_q[3]) begin
            acc_d = (w_width == W_UL) ? {12'h000, mem_data_in[3:0]} : {8'h00, mem_data_in};
          end
          if (func_q[0]) ra1_d = w_ra_upd;
          else           ra0_d = w_ra_upd;
          state_d = S_FETCH;
        end
      end
      S_MEM1: begin
        w_addr = w_ea_p1[14:0];
        if (func_q[3]) begin
          w_wr   = 1'b1;
          w_dout = acc_q[15:8];
        end else begin
          w_rd  = 1'b1;
          acc_d = {mem_data_in, imm_q[7:0]};
        end
        if (func_q[0]) ra1_d = w_ra_upd;
        else           ra0_d = w_ra_upd;
        state_d = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_FETCH;
      pc_q    <= 16'h0000;
      acc_q   <= 16'h0000;
      ra0_q   <= 16'h0000;
      ra1_q   <= 16'h0000;
      carry_q <= 1'b0;
      cfg_q   <= CFG_RESET;
      cnt_q   <= 2'd0;
      imm_q   <= 16'h0000;
      func_q  <= 4'h0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      acc_q   <= acc_d;
      ra0_q   <= ra0_d;
      ra1_q   <= ra1_d;
      carry_q <= carry_d;
      cfg_q   <= cfg_d;
      cnt_q   <= cnt_d;
      imm_q   <= imm_d;
      func_q  <= func_d;
    end
  end

  // Gating by rst also suppresses the second byte of a store cut short by reset.
  assign mem_enable_read  = w_rd & ~rst;
  assign mem_enable_write = w_wr & ~rst;
  assign mem_rw           = w_wr & ~rst;
  assign mem_addr         = rst ? 15'h0000 : w_addr;
  assign mem_data_out     = rst ? 8'h00 : w_dout;
  assign test_data        = acc_q;
  assign test_carry       = carry_q;

endmodule
`default_nettype wire

// File: tb/tb_misa_o.sv
`default_nettype none
// ------------------------------------------------------------------------
// tb_misa_o: random programs vs. an instruction-level model.    Rev 1.0
// ------------------------------------------------------------------------
module tb_misa_o;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_enable_read;
  logic        mem_enable_write;
  logic [7:0]  mem_data_in;
  logic [14:0] mem_addr;
  logic        mem_rw;
  logic [7:0]  mem_data_out;
  logic [15:0] test_data;
  logic        test_carry;

  always #5 clk = ~clk;

  misa_o dut (
    .clk              (clk),
    .rst              (rst),
    .mem_enable_read  (mem_enable_read),
    .mem_enable_write (mem_enable_write),
    .mem_data_in      (mem_data_in),
    .mem_addr         (mem_addr),
    .mem_rw           (mem_rw),
    .mem_data_out     (mem_data_out),
    .test_data        (test_data),
    .test_carry       (test_carry)
  );

  logic [7:0]  mem [0:32767];
  logic        ld_en = 1'b0;
  logic [14:0] ld_addr = 15'h0;
  logic [7:0]  ld_data = 8'h0;

  assign mem_data_in = mem[mem_addr];

  always @(posedge clk) begin
    if (ld_en)                 mem[ld_addr]  <= ld_data;
    else if (mem_enable_write) mem[mem_addr] <= mem_data_out;
  end

  typedef struct { int cyc; logic [15:0] acc; logic c; } st_t;
  typedef struct { int cyc; logic [14:0] a; logic [7:0] d; } wr_t;

  st_t        st_q[$];
  wr_t        wr_q[$];
  logic [3:0] prog[$];
  logic [7:0] ref_mem [0:32767];
  int         n_cmp = 0;
  int         n_bad = 0;
  int         cyc = 0;
  int         gw = 1;
  int         last_cyc = 0;
  bit         mon_on = 1'b0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic int nib_of(input logic [1:0] m);
    return (m == 2'b00) ? 1 : (m == 2'b01) ? 2 : 4;
  endfunction

  task automatic emit(input logic [3:0] n);
    prog.push_back(n);
  endtask

  task automatic emit_cfg(input logic [7:0] c);
    emit(4'hF); emit(4'h0); emit(c[3:0]); emit(c[7:4]);
    gw = nib_of(c[1:0]);
  endtask

  task automatic emit_ldi(input logic [15:0] v);
    emit(4'h1);
    for (int i = 0; i < gw; i++) emit(v[4*i +: 4]);
  endtask

  // Pointers only ever come from here, so stores stay inside the data window.
  task automatic set_ra(input logic [15:0] v);
    int r;
    r = $urandom;
    emit_cfg({r[7:2], 2'b10});
    emit_ldi(v);
    emit(4'hF); emit(4'h1);
  endtask

  // Architectural interpreter: walks the nibble stream, one instruction at a time.
  task automatic run_model();
    int pc, t, nl, k, n;
    logic [15:0] acc, ra0, ra1, ra, ea, ea1, nra, imm, mask, step;
    logic        c;
    logic [7:0]  cfg, b0;
    logic [3:0]  op, f, x;
    pc = 0; t = 0; acc = 0; ra0 = 0; ra1 = 0; c = 0; cfg = 8'h4C;
    st_q.push_back('{0, 16'h0000, 1'b0});
    while (pc < prog.size()) begin
      op   = prog[pc];
      n    = nib_of(cfg[1:0]);
      mask = (n == 1) ? 16'h000F : (n == 2) ? 16'h00FF : 16'hFFFF;
      nl   = 1;
      k    = 1;
      case (op)
        4'h1: begin
          imm = 16'h0;
          for (int i = 0; i < n; i++) imm[4*i +: 4] = prog[pc+1+i];
          acc = imm;
          nl  = 1 + n;
          k   = nl;
        end
        4'h2: begin c = ((acc & mask) == mask);  acc = (acc + 16'd1) & mask; end
        4'h3: begin c = ((acc & mask) == 16'd0); acc = (acc - 16'd1) & mask; end
        4'h4: acc = ~acc & mask;
        4'h5: begin
          f    = prog[pc+1];
          nl   = 2;
          k    = (n == 4) ? 4 : 3;
          step = (n == 4) ? 16'd2 : 16'd1;
          ra   = f[0] ? ra1 : ra0;
          if (f[1]) begin ea = f[2] ? ra - step : ra; nra = ea; end
          else      begin ea = ra; nra = f[2] ? ra + step : ra; end
          ea1 = ea + 16'd1;
          if (f[3]) begin
            b0 = (n == 1) ? {4'h0, acc[3:0]} : acc[7:0];
            ref_mem[ea[14:0]] = b0;
            wr_q.push_back('{t + 2, ea[14:0], b0});
            if (n == 4) begin
              ref_mem[ea1[14:0]] = acc[15:8];
              wr_q.push_back('{t + 3, ea1[14:0], acc[15:8]});
            end
          end else begin
            b0 = ref_mem[ea[14:0]];
            if (n == 1)      acc = {12'h000, b0[3:0]};
            else if (n == 2) acc = {8'h00, b0};
            else             acc = {ref_mem[ea1[14:0]], b0};
          end
          if (f[0]) ra1 = nra; else ra0 = nra;
        end
        4'hF: begin
          x  = prog[pc+1];
          nl = 2;
          k  = 2;
          if (x == 4'h0) begin
            cfg = {prog[pc+3], prog[pc+2]};
            nl  = 4;
            k   = 4;
          end else if (x == 4'h1) begin
            ra1 = ra0; ra0 = acc;
          end else if (x == 4'h2) begin
            ra = ra0; ra0 = ra1; ra1 = ra;
          end
        end
        default: ;
      endcase
      pc += nl;
      t  += k;
      st_q.push_back('{t, acc, c});
    end
    last_cyc = t;
  endtask

  task automatic monitor();
    st_t e;
    wr_t w;
    forever begin
      @(negedge clk);
      if (mon_on) begin
        if (st_q.size() > 0 && st_q[0].cyc == cyc) begin
          e = st_q.pop_front();
          check("acc", 64'(test_data), 64'(e.acc));
          check("carry", 64'(test_carry), 64'(e.c));
        end
        if (mem_enable_write) begin
          if (wr_q.size() == 0) begin
            check("unexpected_wr", 64'(mem_enable_write), 64'd0);
          end else begin
            w = wr_q.pop_front();
            check("wr_cycle", 64'(cyc), 64'(w.cyc));
            check("wr_addr", 64'(mem_addr), 64'(w.a));
            check("wr_data", 64'(mem_data_out), 64'(w.d));
            check("wr_rw", 64'(mem_rw), 64'd1);
          end
        end
        cyc++;
      end
    end
  endtask

  task automatic load_byte(input logic [14:0] a, input logic [7:0] d);
    @(negedge clk);
    check("rst_outs", 64'({mem_enable_read, mem_enable_write, mem_rw, mem_addr,
                           mem_data_out, test_data, test_carry}), 64'd0);
    ld_en = 1'b1; ld_addr = a; ld_data = d;
    @(posedge clk);
    #1 ld_en = 1'b0;
  endtask

  initial begin
    int r, nb, found;
    logic [3:0] lo, hi;
    logic [3:0] p2 [18];
    rst = 1'b1;
    fork monitor(); join_none

    // Random data window shared by the DUT memory and the model.
    for (int a = 16'h4000; a < 16'h4800; a++) begin
      r = $urandom;
      ref_mem[a] = r[7:0];
      load_byte(15'(a), r[7:0]);
    end

    // Directed preamble followed by a random instruction mix.
    gw = 1;
    emit_ldi(16'h0005);
    emit_cfg(8'h4E); emit_ldi(16'h1234);
    set_ra(16'h4280); set_ra(16'h4490);
    emit_cfg(8'h4D); emit_ldi(16'h00FF); emit(4'h2);
    emit_cfg(8'h4C); emit_ldi(16'h0000); emit(4'h3); emit(4'h2);
    for (int i = 0; i < 250; i++) begin
      r = $urandom_range(0, 99);
      if (r < 10) begin
        lo = 4'($urandom_range(6, 15));
        emit((lo == 4'hF) ? 4'h0 : lo);
      end else if (r < 25) begin
        r = $urandom; emit_ldi(r[15:0]);
      end else if (r < 33) emit(4'h2);
      else if (r < 41) emit(4'h3);
      else if (r < 47) emit(4'h4);
      else if (r < 72) begin
        emit(4'h5); emit(4'($urandom_range(0, 15)));
      end else if (r < 80) begin
        r = $urandom; emit_cfg(r[7:0]);
      end else if (r < 84) begin
        emit(4'hF); emit(4'h2);
      end else if (r < 88) begin
        emit(4'hF); emit(4'($urandom_range(3, 15)));
      end else begin
        set_ra(16'($urandom_range(16'h4200, 16'h45FF)));
      end
    end

    nb = (prog.size() + 1) / 2;
    for (int b = 0; b < nb + 64; b++) begin
      lo = (2*b < prog.size())     ? prog[2*b]   : 4'h0;
      hi = (2*b + 1 < prog.size()) ? prog[2*b+1] : 4'h0;
      load_byte(15'(b), {hi, lo});
    end
    run_model();

    @(posedge clk);
    #1 rst = 1'b0;
    cyc = 0;
    mon_on = 1'b1;
    for (int i = 0; i < last_cyc + 200; i++) begin
      if (st_q.size() == 0 && wr_q.size() == 0) break;
      @(posedge clk);
    end
    check("drain_pending", 64'(st_q.size() + wr_q.size()), 64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    mon_on = 1'b0;
    rst = 1'b1;
    for (int a = 16'h4000; a < 16'h4800; a++) check("mem_final", 64'(mem[a]), 64'(ref_mem[a]));

    // LK16 store interrupted by reset during its second data cycle.
    p2 = '{4'hF, 4'h0, 4'hE, 4'h4, 4'h1, 4'h0, 4'h9, 4'h0, 4'h0,
           4'hF, 4'h1, 4'h1, 4'h4, 4'h3, 4'h2, 4'h1, 4'h5, 4'h8};
    for (int b = 0; b < 9; b++) load_byte(15'(b), {p2[2*b+1], p2[2*b]});
    load_byte(15'h0090, 8'h00);
    load_byte(15'h0091, 8'h00);
    @(posedge clk);
    #1 rst = 1'b0;
    found = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (mem_enable_write && mem_addr == 15'h0091) begin
        found = 1;
        break;
      end
    end
    check("mem1_store_seen", 64'(found), 64'd1);
    rst = 1'b1;
    #1;
    check("rst_gates_wr", 64'({mem_enable_write, mem_rw, mem_addr, mem_data_out}), 64'd0);
    @(posedge clk);
    #1;
    check("low_byte_kept", 64'(mem[15'h0090]), 64'h34);
    check("high_byte_skipped", 64'(mem[15'h0091]), 64'h00);
    check("acc_after_rst", 64'({test_data, test_carry}), 64'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("pc0_addr", 64'(mem_addr), 64'd0);
    check("pc0_acc", 64'({test_data, test_carry}), 64'd0);
    @(negedge clk);
    check("pc1_addr", 64'(mem_addr), 64'd0);
    @(negedge clk);
    check("pc2_addr", 64'(mem_addr), 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/misa_o.md
# misa_o

Nibble-serial accumulator CPU core, 16-bit datapath. Fetches 4-bit opcodes from a shared byte-wide memory, low nibble of each byte first. Supports configurable data width: UL = 4-bit, LK8 = 8-bit, LK16 = 16-bit. Provides two address registers (RA0/RA1) for memory load/store with optional stack-style pointer update. Sits at the top of the processor, drives the single memory port, and exposes ACC and carry for test observation.

## Interface
- No parameters.
- Clock and reset: one clock; reset is synchronous and active-high.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `mem_enable_read`  out  1  read strobe; asserted on fetch and load cycles.
- `mem_enable_write`  out  1  write strobe; memory writes `mem_data_out` at `mem_addr` on this clock edge.
- `mem_data_in`  in  8  asynchronous read data for `mem_addr`, sampled in the same cycle.
- `mem_addr`  out  15  byte address.
- `mem_rw`  out  1  1 = write cycle, 0 = read/idle.
- `mem_data_out`  out  8  store data.
- `test_data`  out  16  current ACC.
- `test_carry`  out  1  current carry flag.

## Operation
- State:
  - PC: 16-bit nibble pointer.
  - ACC, RA0, RA1: 16 bits each.
  - carry: 1 bit.
  - cfg: 8 bits.
- Fetch: `mem_addr`=PC[15:1]; nibble = PC[0] ? `mem_data_in`[7:4] : [3:0]. One nibble per cycle, then PC+1. PC wraps at 0xFFFF.
- Width mode = cfg[1:0]: 00 UL, 01 LK8, 10 LK16, 11 treated as LK16. Other cfg bits are stored with no effect. Width in nibbles N = 1 / 2 / 4.
- Opcodes:
  - 0 NOP.
  - 1 LDI: next N nibbles, least significant first; ACC ← zero-extended immediate.
  - 2 INC: ACC ← (ACC+1) masked to width, zero-extended. carry ← overflow out of width.
  - 3 DEC: ACC ← (ACC−1) masked to width. carry ← borrow.
  - 4 NOT: ACC ← ~ACC masked to width. carry unchanged.
  - 5 XMEM: next nibble is function f.
  - F XOP: next nibble is the extended opcode.
  - 6–E: reserved, execute as NOP.
- Extended opcodes:
  - 0 CFG: next two nibbles form cfg (low nibble first).
  - 1 SA: RA1 ← RA0, RA0 ← ACC; ACC unchanged.
  - 2 RSA: swap RA0 and RA1.
  - Others: NOP.
- XMEM function nibble: f[3] store(1)/load(0); f[2] AM (pointer update enable); f[1] DIR (0 = post-increment, 1 = pre-decrement); f[0] AR (0 = RA0, 1 = RA1).
- XMEM addressing:
  - step = 1 for UL/LK8, 2 for LK16.
  - DIR=0: EA = RA; if AM, RA ← RA+step.
  - DIR=1: EA = AM ? RA−step : RA; if AM, RA ← EA.
  - All address arithmetic is mod 2^16; `mem_addr` = EA[14:0].
- Store data:
  - UL writes {4'h0, ACC[3:0]}.
  - LK8 writes ACC[7:0].
  - LK16 writes ACC[7:0] at EA, then ACC[15:8] at EA+1 (little-endian).
- Load: ACC ← zero-extended data of the current width, LK16 little-endian. UL takes `mem_data_in`[3:0].
- LDI and XMEM do not change carry.

## Timing
- FSM states:
  - FETCH: decode opcode.
  - IMM: LDI operand nibbles.
  - XOPX: extended opcode nibble.
  - CFG0, CFG1: cfg nibbles.
  - XFUNC: XMEM function nibble.
  - MEM0, MEM1: data access cycles; PC does not advance in these.
- Every nibble costs one cycle.
- XMEM cycle count: 2 + 1 cycles for UL/LK8, 2 + 2 cycles for LK16.
- Data cycles: `mem_addr` = EA (MEM1: EA+1). Load: `mem_enable_read`=1, `mem_rw`=0. Store: `mem_enable_write`=1, `mem_rw`=1.
- Load data, register updates and pointer update all take effect at the end of the last data cycle.
- A result becomes visible on `test_data` one edge after the final nibble or data cycle of the instruction.
- Reset values:
  - PC=0, ACC=0, RA0=RA1=0, carry=0, cfg=0x4C (UL), state FETCH.
  - While `rst` is high: `mem_enable_read`=`mem_enable_write`=`mem_rw`=0, `mem_addr`=0, `mem_data_out`=0.
- Reset mid-instruction (e.g. during MEM1 of an LK16 store): the high byte is not written; the low byte already written remains. All state returns to reset values.

## Structure
- Package `misa_o_pkg`: opcode and extended-opcode constants, width-mode enum, FSM state enum, `CFG_RESET`=8'h4C.
- Sub-module `misa_o_agu`: computes EA, EA+1 and the updated RA from RA, f[2:1] and width.

## Test plan
Bytes are packed two nibbles per byte, low nibble first.

- Reset with memory zeroed → `mem_addr`=0 and outputs zero during reset. After release, PC advances one nibble per cycle and `test_data`=0, `test_carry`=0.
- UL stream 1,5 → ACC=0x0005. LK16 stream F,0,E,4, 1,4,3,2,1 → ACC=0x1234.
- LK16:
  - LDI 0x0080, XOP SA, LDI 0x0090, XOP SA, XOP RSA.
  - LDI 0x1234, XMEM D → mem[0x90]=0x34, mem[0x91]=0x12.
  - LDI 0, XMEM 7 → ACC=0x1234.
- Continuing from the previous scenario:
  - UL LDI 5, XMEM C → mem[0x80]=0x05, RA0=0x81.
  - LK8 LDI 0x5B, XMEM 8 → mem[0x81]=0x5B.
  - XMEM 0 → ACC=0x005B.
- INC/DEC carry:
  - LK8 LDI 0xFF, INC → ACC=0x0000, carry=1.
  - UL LDI 0, DEC → ACC=0x000F, carry=1.
  - INC → ACC=0x0000, carry=1.
- LK16 store: assert `rst` in MEM1 → only the low byte is written; `mem_enable_write` is 0; PC=0.
